// File: rtl/score_update_arbiter_if.sv
// Request, shared-adder and score/status bundle of the scoreboard arbiter.
// slave = arbiter side, master = requester/adder/display side.
interface score_update_arbiter_if;
  logic       clr;
  logic       req_home;
  logic       sub_home;
  logic [1:0] pts_home;
  logic       req_away;
  logic       sub_away;
  logic [1:0] pts_away;
  logic [6:0] add_a;
  logic [1:0] add_b;
  logic       add_cin;
  logic [6:0] add_s;
  logic       add_cout;
  logic [6:0] score_home;
  logic [6:0] score_away;
  logic       ack_home;
  logic       ack_away;
  logic       drop_home;
  logic       drop_away;
  logic       busy;

  modport slave (
    input  clr, req_home, sub_home, pts_home, req_away, sub_away, pts_away,
    input  add_s, add_cout,
    output add_a, add_b, add_cin,
    output score_home, score_away, ack_home, ack_away, drop_home, drop_away, busy
  );

  modport master (
    output clr, req_home, sub_home, pts_home, req_away, sub_away, pts_away,
    output add_s, add_cout,
    input  add_a, add_b, add_cin,
    input  score_home, score_away, ack_home, ack_away, drop_home, drop_away, busy
  );
endinterface

// File: rtl/score_update_arbiter.sv
// Owns home/away scores, buffers one request per team, round-robins them through one external adder.
// Request to write-back is two cycles; a request hitting a full, non-granted slot is dropped and flagged.
module score_update_arbiter #(
  parameter int unsigned MAX_SCORE = 99
) (
  input  logic                  clk,
  input  logic                  rst,
  score_update_arbiter_if.slave sb_io
);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic {HOME, AWAY} team_t;

  typedef struct packed {
    logic       vld;
    logic       sub;
    logic [1:0] pts;
  } slot_t;

  localparam logic [6:0] MAX = 7'(MAX_SCORE);

  state_t     state_q, state_d;
  team_t      rr_last_q, rr_last_d;
  team_t      gnt_q, gnt_d;
  slot_t      home_slot_q, home_slot_d;
  slot_t      away_slot_q, away_slot_d;
  logic [6:0] score_home_q, score_home_d;
  logic [6:0] score_away_q, score_away_d;
  logic [6:0] add_a_q, add_a_d;
  logic [1:0] add_b_q, add_b_d;
  logic       add_cin_q, add_cin_d;
  logic       ack_home_q, ack_home_d;
  logic       ack_away_q, ack_away_d;
  logic       drop_home_q, drop_home_d;
  logic       drop_away_q, drop_away_d;

  logic       gnt_home;
  logic       gnt_away;
  logic [6:0] result;

  // On a tie the team that was not served last goes first.
  assign gnt_home = (state_q == IDLE) && home_slot_q.vld &&
                    (!away_slot_q.vld || (rr_last_q == AWAY));
  assign gnt_away = (state_q == IDLE) && away_slot_q.vld && !gnt_home;

  // Subtract runs as A + ~B + 1, so a missing carry-out means a borrow.
  always_comb begin
    result = sb_io.add_s;
    if (add_cin_q) begin
      if (!sb_io.add_cout) result = 7'd0;
    end else if (sb_io.add_cout || (sb_io.add_s > MAX)) begin
      result = MAX;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    gnt_d        = gnt_q;
    home_slot_d  = home_slot_q;
    away_slot_d  = away_slot_q;
    score_home_d = score_home_q;
    score_away_d = score_away_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cin_d    = add_cin_q;
    ack_home_d   = 1'b0;
    ack_away_d   = 1'b0;
    drop_home_d  = 1'b0;
    drop_away_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_home) begin
          add_a_d         = score_home_q;
          add_b_d         = home_slot_q.pts;
          add_cin_d       = home_slot_q.sub;
          gnt_d           = HOME;
          rr_last_d       = HOME;
          home_slot_d.vld = 1'b0;
          state_d         = EXEC;
        end else if (gnt_away) begin
          add_a_d         = score_away_q;
          add_b_d         = away_slot_q.pts;
          add_cin_d       = away_slot_q.sub;
          gnt_d           = AWAY;
          rr_last_d       = AWAY;
          away_slot_d.vld = 1'b0;
          state_d         = EXEC;
        end
      end
      EXEC: begin
        if (gnt_q == HOME) begin
          score_home_d = result;
          ack_home_d   = 1'b1;
        end else begin
          score_away_d = result;
          ack_away_d   = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A slot granted on this edge can be refilled on the same edge.
    if (sb_io.req_home) begin
      if (!home_slot_q.vld || gnt_home) begin
        home_slot_d.vld = 1'b1;
        home_slot_d.sub = sb_io.sub_home;
        home_slot_d.pts = sb_io.pts_home;
      end else begin
        drop_home_d = 1'b1;
      end
    end
    if (sb_io.req_away) begin
      if (!away_slot_q.vld || gnt_away) begin
        away_slot_d.vld = 1'b1;
        away_slot_d.sub = sb_io.sub_away;
        away_slot_d.pts = sb_io.pts_away;
      end else begin
        drop_away_d = 1'b1;
      end
    end

    if (sb_io.clr) begin
      state_d      = IDLE;
      rr_last_d    = rr_last_q;
      home_slot_d  = '0;
      away_slot_d  = '0;
      score_home_d = 7'd0;
      score_away_d = 7'd0;
      ack_home_d   = 1'b0;
      ack_away_d   = 1'b0;
      drop_home_d  = 1'b0;
      drop_away_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_last_q    <= AWAY;
      gnt_q        <= HOME;
      home_slot_q  <= '0;
      away_slot_q  <= '0;
      score_home_q <= 7'd0;
      score_away_q <= 7'd0;
      add_a_q      <= 7'd0;
      add_b_q      <= 2'd0;
      add_cin_q    <= 1'b0;
      ack_home_q   <= 1'b0;
      ack_away_q   <= 1'b0;
      drop_home_q  <= 1'b0;
      drop_away_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      gnt_q        <= gnt_d;
      home_slot_q  <= home_slot_d;
      away_slot_q  <= away_slot_d;
      score_home_q <= score_home_d;
      score_away_q <= score_away_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cin_q    <= add_cin_d;
      ack_home_q   <= ack_home_d;
      ack_away_q   <= ack_away_d;
      drop_home_q  <= drop_home_d;
      drop_away_q  <= drop_away_d;
    end
  end

  assign sb_io.add_a      = add_a_q;
  assign sb_io.add_b      = add_b_q;
  assign sb_io.add_cin    = add_cin_q;
  assign sb_io.score_home = score_home_q;
  assign sb_io.score_away = score_away_q;
  assign sb_io.ack_home   = ack_home_q;
  assign sb_io.ack_away   = ack_away_q;
  assign sb_io.drop_home  = drop_home_q;
  assign sb_io.drop_away  = drop_away_q;
  assign sb_io.busy       = (state_q == EXEC) || home_slot_q.vld || away_slot_q.vld;

endmodule

// File: tb/tb_score_update_arbiter.sv
// Directed bench for score_update_arbiter with a behavioural 7-bit adder on the shared port.
module tb_score_update_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   drops_h;
  int   drops_a;

  score_update_arbiter_if bus();

  score_update_arbiter #(.MAX_SCORE(99)) dut (
    .clk   (clk),
    .rst   (rst),
    .sb_io (bus)
  );

  // Shared adder: A + B, or A + ~B + 1 when cin is set.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a}
                                   + {1'b0, (bus.add_cin ? ~{5'b0, bus.add_b} : {5'b0, bus.add_b})}
                                   + {7'b0, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.drop_home) drops_h++;
    if (bus.drop_away) drops_a++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic op_home(input logic s, input logic [1:0] p);
    bus.req_home = 1'b1; bus.sub_home = s; bus.pts_home = p;
    tick();
    bus.req_home = 1'b0;
  endtask

  task automatic op_away(input logic s, input logic [1:0] p);
    bus.req_away = 1'b1; bus.sub_away = s; bus.pts_away = p;
    tick();
    bus.req_away = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({bus.score_home, bus.score_away} !== 14'd0) begin
      n_fail++; $display("FAIL reset_scores got %0d/%0d want 0/0", bus.score_home, bus.score_away);
    end
    n_tests++;
    if ({bus.add_a, bus.add_b, bus.add_cin} !== 10'd0) begin
      n_fail++; $display("FAIL reset_add got %0d/%0d/%0d want 0/0/0", bus.add_a, bus.add_b, bus.add_cin);
    end
    n_tests++;
    if ({bus.ack_home, bus.ack_away, bus.drop_home, bus.drop_away, bus.busy} !== 5'd0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000",
                         {bus.ack_home, bus.ack_away, bus.drop_home, bus.drop_away, bus.busy});
    end
    rst = 1'b0;
    // Reset during EXEC abandons the operation.
    op_home(1'b0, 2'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus.score_home !== 7'd0 || bus.ack_home !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_exec got score=%0d ack=%b busy=%b want 0/0/0",
                         bus.score_home, bus.ack_home, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.ack_home !== 1'b0 || bus.score_home !== 7'd0) begin
      n_fail++; $display("FAIL reset_mid_exec_after got ack=%b score=%0d want 0/0", bus.ack_home, bus.score_home);
    end
  endtask

  task automatic test_single();
    do_reset();
    op_home(1'b0, 2'd3);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.score_home !== 7'd0) begin
      n_fail++; $display("FAIL single_pend got busy=%b score=%0d want 1/0", bus.busy, bus.score_home);
    end
    tick();
    n_tests++;
    if (bus.add_a !== 7'd0 || bus.add_b !== 2'd3 || bus.add_cin !== 1'b0 || bus.ack_home !== 1'b0) begin
      n_fail++; $display("FAIL single_exec got a=%0d b=%0d cin=%b ack=%b want 0/3/0/0",
                         bus.add_a, bus.add_b, bus.add_cin, bus.ack_home);
    end
    tick();
    n_tests++;
    if (bus.score_home !== 7'd3 || bus.ack_home !== 1'b1 || bus.score_away !== 7'd0) begin
      n_fail++; $display("FAIL single_wb got home=%0d ack=%b away=%0d want 3/1/0",
                         bus.score_home, bus.ack_home, bus.score_away);
    end
    tick();
    n_tests++;
    if (bus.ack_home !== 1'b0 || bus.busy !== 1'b0 || bus.add_b !== 2'd3) begin
      n_fail++; $display("FAIL single_after got ack=%b busy=%b b=%0d want 0/0/3", bus.ack_home, bus.busy, bus.add_b);
    end
  endtask

  task automatic test_tie();
    int dh0, da0;
    do_reset();
    dh0 = drops_h; da0 = drops_a;
    bus.req_home = 1'b1; bus.sub_home = 1'b0; bus.pts_home = 2'd2;
    bus.req_away = 1'b1; bus.sub_away = 1'b0; bus.pts_away = 2'd2;
    tick();
    bus.req_away = 1'b0;
    bus.pts_home = 2'd1;
    tick();
    bus.req_home = 1'b0;
    n_tests++;
    if (bus.add_a !== 7'd0 || bus.add_b !== 2'd2) begin
      n_fail++; $display("FAIL tie_first_exec got a=%0d b=%0d want 0/2", bus.add_a, bus.add_b);
    end
    tick();
    n_tests++;
    if (bus.score_home !== 7'd2 || bus.ack_home !== 1'b1 || bus.score_away !== 7'd0 || bus.ack_away !== 1'b0) begin
      n_fail++; $display("FAIL tie_home_wb got home=%0d ack_h=%b away=%0d ack_a=%b want 2/1/0/0",
                         bus.score_home, bus.ack_home, bus.score_away, bus.ack_away);
    end
    tick();
    n_tests++;
    if (bus.add_a !== 7'd0 || bus.add_b !== 2'd2 || bus.ack_home !== 1'b0) begin
      n_fail++; $display("FAIL tie_away_exec got a=%0d b=%0d ack_h=%b want 0/2/0", bus.add_a, bus.add_b, bus.ack_home);
    end
    tick();
    n_tests++;
    if (bus.score_away !== 7'd2 || bus.ack_away !== 1'b1 || bus.score_home !== 7'd2) begin
      n_fail++; $display("FAIL tie_away_wb got away=%0d ack_a=%b home=%0d want 2/1/2",
                         bus.score_away, bus.ack_away, bus.score_home);
    end
    tick();
    n_tests++;
    if (bus.add_a !== 7'd2 || bus.add_b !== 2'd1) begin
      n_fail++; $display("FAIL tie_home2_exec got a=%0d b=%0d want 2/1", bus.add_a, bus.add_b);
    end
    tick();
    n_tests++;
    if (bus.score_home !== 7'd3 || bus.ack_home !== 1'b1 || (drops_h - dh0) !== 0 || (drops_a - da0) !== 0) begin
      n_fail++; $display("FAIL tie_home2_wb got home=%0d ack=%b drops=%0d/%0d want 3/1/0/0",
                         bus.score_home, bus.ack_home, drops_h - dh0, drops_a - da0);
    end
  endtask

  task automatic test_clamp();
    int dh0;
    do_reset();
    op_away(1'b0, 2'd1);
    tick(); tick();
    op_away(1'b1, 2'd3);
    tick(); tick();
    n_tests++;
    if (bus.score_away !== 7'd0 || bus.ack_away !== 1'b1) begin
      n_fail++; $display("FAIL clamp_borrow got away=%0d ack=%b want 0/1", bus.score_away, bus.ack_away);
    end
    dh0 = drops_h;
    for (int i = 0; i < 32; i++) begin
      op_home(1'b0, 2'd3);
      tick();
    end
    tick();
    n_tests++;
    if (bus.score_home !== 7'd96 || (drops_h - dh0) !== 0) begin
      n_fail++; $display("FAIL clamp_stream got home=%0d drops=%0d want 96/0", bus.score_home, drops_h - dh0);
    end
    op_home(1'b0, 2'd2);
    tick(); tick();
    n_tests++;
    if (bus.score_home !== 7'd98) begin
      n_fail++; $display("FAIL clamp_98 got %0d want 98", bus.score_home);
    end
    op_home(1'b0, 2'd3);
    tick(); tick();
    n_tests++;
    if (bus.score_home !== 7'd99 || bus.ack_home !== 1'b1) begin
      n_fail++; $display("FAIL clamp_max got home=%0d ack=%b want 99/1", bus.score_home, bus.ack_home);
    end
    op_home(1'b1, 2'd2);
    tick(); tick();
    n_tests++;
    if (bus.score_home !== 7'd97 || bus.score_away !== 7'd0) begin
      n_fail++; $display("FAIL clamp_sub got home=%0d away=%0d want 97/0", bus.score_home, bus.score_away);
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.req_home = 1'b1; bus.sub_home = 1'b0; bus.pts_home = 2'd1;
    tick(); tick(); tick();
    bus.req_home = 1'b0;
    n_tests++;
    if (bus.drop_home !== 1'b1 || bus.ack_home !== 1'b1 || bus.score_home !== 7'd1 || bus.drop_away !== 1'b0) begin
      n_fail++; $display("FAIL drop_third got drop=%b ack=%b score=%0d drop_a=%b want 1/1/1/0",
                         bus.drop_home, bus.ack_home, bus.score_home, bus.drop_away);
    end
    tick();
    n_tests++;
    if (bus.drop_home !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL drop_pulse got drop=%b busy=%b want 0/1", bus.drop_home, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.score_home !== 7'd2 || bus.ack_home !== 1'b1) begin
      n_fail++; $display("FAIL drop_second got score=%0d ack=%b want 2/1", bus.score_home, bus.ack_home);
    end
    tick(); tick();
    n_tests++;
    if (bus.score_home !== 7'd2 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_final got score=%0d busy=%b want 2/0", bus.score_home, bus.busy);
    end
  endtask

  task automatic test_clr();
    do_reset();
    op_home(1'b0, 2'd2);
    op_away(1'b0, 2'd3);
    tick(); tick(); tick();
    n_tests++;
    if (bus.score_home !== 7'd2 || bus.score_away !== 7'd3) begin
      n_fail++; $display("FAIL clr_setup got %0d/%0d want 2/3", bus.score_home, bus.score_away);
    end
    op_home(1'b0, 2'd1);
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    n_tests++;
    if (bus.score_home !== 7'd0 || bus.score_away !== 7'd0 || bus.ack_home !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_exec got home=%0d away=%0d ack=%b busy=%b want 0/0/0/0",
                         bus.score_home, bus.score_away, bus.ack_home, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.ack_home !== 1'b0 || bus.score_home !== 7'd0) begin
      n_fail++; $display("FAIL clr_after got ack=%b home=%0d want 0/0", bus.ack_home, bus.score_home);
    end
  endtask

  task automatic test_zero_pts();
    int dh0;
    do_reset();
    dh0 = drops_h;
    op_home(1'b1, 2'd0);
    tick();
    n_tests++;
    if (bus.add_cin !== 1'b1 || bus.add_b !== 2'd0 || bus.ack_home !== 1'b0) begin
      n_fail++; $display("FAIL zero_exec got cin=%b b=%0d ack=%b want 1/0/0", bus.add_cin, bus.add_b, bus.ack_home);
    end
    tick();
    n_tests++;
    if (bus.ack_home !== 1'b1 || bus.score_home !== 7'd0 || (drops_h - dh0) !== 0) begin
      n_fail++; $display("FAIL zero_wb got ack=%b score=%0d drops=%0d want 1/0/0",
                         bus.ack_home, bus.score_home, drops_h - dh0);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; drops_h = 0; drops_a = 0;
    rst = 1'b1;
    bus.clr = 1'b0;
    bus.req_home = 1'b0; bus.sub_home = 1'b0; bus.pts_home = 2'd0;
    bus.req_away = 1'b0; bus.sub_away = 1'b0; bus.pts_away = 2'd0;
    test_reset();
    test_single();
    test_tie();
    test_clamp();
    test_drop();
    test_clr();
    test_zero_pts();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
